// File: rtl/div_unit_mc.sv
// rtl/div_unit_mc.sv - multi-cycle radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU)
module div_unit_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             rem_sel_q, rem_sel_d;
    logic             b_zero_q, b_zero_d;
    logic             ovf_q, ovf_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             last_iter;

    always_comb begin
        a_neg     = ~op[0] & a[WIDTH-1];
        b_neg     = ~op[0] & b[WIDTH-1];
        a_abs     = a_neg ? (~a + WIDTH'(1)) : a;
        b_abs     = b_neg ? (~b + WIDTH'(1)) : b;
        // Shifted partial remainder can reach 2*divisor-1, so one extra bit plus a borrow bit
        rem_sh    = {rem_q, quot_q[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, dvsr_q};
        quot_fix  = qneg_q ? (~quot_q + WIDTH'(1)) : quot_q;
        rem_fix   = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
        last_iter = (count_q == CNT_W'(WIDTH-1));
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        a_d       = a_q;
        result_d  = result_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        rem_sel_d = rem_sel_q;
        b_zero_d  = b_zero_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d   = CALC;
                    count_d   = '0;
                    rem_d     = '0;
                    quot_d    = a_abs;
                    dvsr_d    = b_abs;
                    a_d       = a;
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    rem_sel_d = op[1];
                    b_zero_d  = (b == '0);
                    ovf_d     = ~op[0] & (a == MIN_NEG) & (&b);
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (!diff[WIDTH+1]) begin
                        rem_d  = diff[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = rem_sh[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (b_zero_q) begin
                        result_d = rem_sel_q ? a_q : '1;
                    end else if (ovf_q) begin
                        result_d = rem_sel_q ? '0 : MIN_NEG;
                    end else begin
                        result_d = rem_sel_q ? rem_fix : quot_fix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            a_q       <= '0;
            result_q  <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            b_zero_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dvsr_q    <= dvsr_d;
            a_q       <= a_d;
            result_q  <= result_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            rem_sel_q <= rem_sel_d;
            b_zero_q  <= b_zero_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign stall  = ((state_q == IDLE) && start && !flush) || busy;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit_mc.sv
// tb/tb_div_unit_mc.sv - randomized self-checking bench for div_unit_mc
module tb_div_unit_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp;

    div_unit_mc #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .stall(stall), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics from plain 64-bit arithmetic; -2^31/-1 needs no special case here
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (o[0]) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        if (y == 32'd0) begin
            q = -1;
            r = sx;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Caller is at a negedge with the DUT in IDLE; cycle 0 is that IDLE cycle
    task automatic do_div(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp,
                          input bit toggle, input bit keep);
        int cyc;
        int stall_bad;
        cyc = 0;
        stall_bad = 0;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        while (cyc < 60 && !done) begin
            if (!stall) stall_bad++;
            tick();
            cyc++;
            if (toggle && cyc < 30) begin
                op = 2'($urandom);
                a = $urandom;
                b = $urandom;
            end
        end
        check({tag, "_lat"}, 32'(cyc), 32'd34);
        check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
        check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
        check({tag, "_res"}, result, exp);
        last_exp = exp;
        if (!keep) start = 1'b0;
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;

    vec_t vecs[12] = '{
        '{2'b01, 32'd100,      32'd7,          32'd14},
        '{2'b11, 32'd100,      32'd7,          32'd2},
        '{2'b00, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD},
        '{2'b10, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF},
        '{2'b10, 32'd7,        32'hFFFFFFFE,   32'd1},
        '{2'b00, 32'd5,        32'd0,          32'hFFFFFFFF},
        '{2'b01, 32'd5,        32'd0,          32'hFFFFFFFF},
        '{2'b10, 32'd5,        32'd0,          32'd5},
        '{2'b10, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFB},
        '{2'b00, 32'h80000000, 32'hFFFFFFFF,   32'h80000000},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF,   32'd0},
        '{2'b01, 32'h80000000, 32'hFFFFFFFF,   32'd0}
    };

    initial begin
        int dcnt;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        tick();
        tick();
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_div($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e, 1'b0, 1'b0);
        end

        // flush at cycle 10
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result", result, last_exp);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            tick();
        end
        check("flush_no_done", 32'(dcnt), 32'd0);
        do_div("after_flush", 2'b01, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);

        // flush in IDLE blocks acceptance
        start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'b0, stall}, 32'd0);
        tick();
        check("idle_flush_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;
        tick();

        // reset at cycle 20
        start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd17;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_result", result, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            tick();
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);

        // back-to-back with start held, operands toggled during CALC
        do_div("b2b_1", 2'b00, 32'hFFFFFC18, 32'd7, ref_div(2'b00, 32'hFFFFFC18, 32'd7), 1'b1, 1'b1);
        do_div("b2b_2", 2'b11, 32'd999999, 32'd1000, 32'd999, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            case ($urandom_range(0, 5))
                0: begin rx = $urandom; ry = 32'd0; end
                1: begin rx = $urandom; ry = 32'($urandom_range(1, 20)); end
                2: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                3: begin rx = 32'($urandom_range(0, 50)); ry = $urandom; end
                default: begin rx = $urandom; ry = $urandom >> $urandom_range(0, 31); end
            endcase
            do_div($sformatf("rnd%0d", i), ro, rx, ry, ref_div(ro, rx, ry), i[0], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
